// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control, flag and branch-LUT write bus between decode/ALU side and pc_fetch_ctl
interface pc_fetch_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
);
  logic              start;
  logic              halt_in;
  logic              branch_en;
  logic              eq;
  logic [LUT_AW-1:0] br_idx;
  logic              sc_out;
  logic              sc_we;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              sc_q;
  logic              running;
  logic              done;
  logic              overrun;
  modport master (
    output start, halt_in, branch_en, eq, br_idx, sc_out, sc_we, lut_we, lut_waddr, lut_wdata,
    input  pc, sc_q, running, done, overrun
  );
  modport slave (
    input  start, halt_in, branch_en, eq, br_idx, sc_out, sc_we, lut_we, lut_waddr, lut_wdata,
    output pc, sc_q, running, done, overrun
  );
endinterface

// File: rtl/pc_fetch_ctl.sv
// pc_fetch_ctl: program counter, branch-target LUT, carry flag and start/halt/done control; define PC_FETCH_BRANCH_REL_EN for PC-relative LUT entries
module pc_fetch_ctl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input logic       CLK,
  input logic       RESET_N,
  pc_fetch_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] tgt;
  logic            sc_q;
  logic            ovr;
  logic [PC_W-1:0] lut [2**LUT_AW];
`ifdef PC_FETCH_BRANCH_REL_EN
  assign tgt = pc + lut[bus.br_idx];
`else
  assign tgt = lut[bus.br_idx];
`endif
  // control state, program counter, carry flag and sticky overrun
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      pc    <= '0;
      sc_q  <= 1'b0;
      ovr   <= 1'b0;
    end else if (state == S_RUN) begin
      if (bus.halt_in) state <= S_HALT;
      else if (bus.branch_en && bus.eq) pc <= tgt;
      else if (&pc) begin
        state <= S_HALT;
        ovr   <= 1'b1;
      end else pc <= pc + 1'b1;
      if (bus.sc_we && !bus.halt_in) sc_q <= bus.sc_out;
    end else if (bus.start) begin
      state <= S_RUN;
      pc    <= '0;
      sc_q  <= 1'b0;
      ovr   <= 1'b0;
    end else if (state != S_HALT) begin
      state <= S_IDLE;
      pc    <= '0;
    end
  end
  // branch-target table; a same-cycle branch reads the entry before this write lands
  always_ff @(posedge CLK) begin
    if (!RESET_N) for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
    else if (bus.lut_we) lut[bus.lut_waddr] <= bus.lut_wdata;
  end
  assign bus.pc      = pc;
  assign bus.sc_q    = sc_q;
  assign bus.running = state == S_RUN;
  assign bus.done    = state == S_HALT;
  assign bus.overrun = ovr;
endmodule

// File: tb/tb_pc_fetch_ctl.sv
// tb_pc_fetch_ctl: vector table, corner sequences and randomized run against a reference model
module tb_pc_fetch_ctl;
  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;
  localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int nchk = 0;
  int nerr = 0;
  pc_fetch_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();
  pc_fetch_ctl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    logic rn, st, hl, br, eq, so, swe, lwe;
    logic [LUT_AW-1:0] idx, wa;
    logic [PC_W-1:0] wd;
  } in_t;
  typedef struct {
    in_t i;
    logic [PC_W-1:0] pc;
    logic sc, run, done, ovr;
  } vec_t;
  vec_t tbl[$];
  in_t cur;
  in_t nop;
  logic [PC_W-1:0] m_lut [2**LUT_AW];
  logic [PC_W-1:0] m_pc;
  logic m_sc, m_run, m_done, m_ovr;
  function automatic logic [PC_W-1:0] tgt(logic [PC_W-1:0] p, logic [PC_W-1:0] e);
`ifdef PC_FETCH_BRANCH_REL_EN
    return p + e;
`else
    return e;
`endif
  endfunction
  task automatic model_step();
    if (!cur.rn) begin
      m_pc = '0; m_sc = 0; m_run = 0; m_done = 0; m_ovr = 0;
      foreach (m_lut[k]) m_lut[k] = '0;
      return;
    end
    if (m_run) begin
      if (cur.hl) begin m_run = 0; m_done = 1; end
      else if (cur.br && cur.eq) m_pc = tgt(m_pc, m_lut[cur.idx]);
      else if (m_pc == PC_MAX) begin m_run = 0; m_done = 1; m_ovr = 1; end
      else m_pc = m_pc + 1'b1;
      if (cur.swe && !cur.hl) m_sc = cur.so;
    end else if (cur.st) begin
      m_run = 1; m_done = 0; m_pc = '0; m_sc = 0; m_ovr = 0;
    end
    if (cur.lwe) m_lut[cur.wa] = cur.wd;
  endtask
  task automatic apply(input in_t x);
    cur = x;
    RESET_N = x.rn;
    bus.start = x.st; bus.halt_in = x.hl; bus.branch_en = x.br; bus.eq = x.eq;
    bus.br_idx = x.idx; bus.sc_out = x.so; bus.sc_we = x.swe;
    bus.lut_we = x.lwe; bus.lut_waddr = x.wa; bus.lut_wdata = x.wd;
  endtask
  task automatic tick(input in_t x);
    apply(x);
    @(posedge CLK);
    model_step();
    #1;
  endtask
  task automatic chk(input string n, input int a, input int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_all(input string tag, input logic [PC_W-1:0] pc, input logic sc, input logic run, input logic done, input logic ovr);
    chk({tag, " pc"}, int'(bus.pc), int'(pc));
    chk({tag, " sc_q"}, int'(bus.sc_q), int'(sc));
    chk({tag, " running"}, int'(bus.running), int'(run));
    chk({tag, " done"}, int'(bus.done), int'(done));
    chk({tag, " overrun"}, int'(bus.overrun), int'(ovr));
  endtask
  task automatic add(input in_t x, input logic [PC_W-1:0] pc, input logic sc, input logic run, input logic done, input logic ovr);
    tbl.push_back('{x, pc, sc, run, done, ovr});
  endtask
  initial begin
    in_t x;
    logic [PC_W-1:0] a, b, c;
    nop = '{rn: 1'b1, default: '0};
    a = tgt(10'd5, 10'h040);
    b = tgt(a + 1'b1, 10'h040);
    c = tgt(b, 10'h007);
    x = nop; x.rn = 0;                              add(x, 0, 0, 0, 0, 0);
    x = nop; x.lwe = 1; x.wa = 3; x.wd = 10'h040;   add(x, 0, 0, 0, 0, 0);
    x = nop; x.st = 1;                              add(x, 0, 0, 1, 0, 0);
    x = nop;                                        add(x, 1, 0, 1, 0, 0);
    x = nop;                                        add(x, 2, 0, 1, 0, 0);
    x = nop; x.swe = 1; x.so = 1;                   add(x, 3, 1, 1, 0, 0);
    x = nop;                                        add(x, 4, 1, 1, 0, 0);
    x = nop; x.br = 1; x.idx = 3;                   add(x, 5, 1, 1, 0, 0);
    x = nop; x.br = 1; x.eq = 1; x.idx = 3;         add(x, a, 1, 1, 0, 0);
    x = nop;                                        add(x, a + 1'b1, 1, 1, 0, 0);
    x = nop; x.br = 1; x.eq = 1; x.idx = 3; x.lwe = 1; x.wa = 3; x.wd = 10'h007;
                                                    add(x, b, 1, 1, 0, 0);
    x = nop; x.br = 1; x.eq = 1; x.idx = 3;         add(x, c, 1, 1, 0, 0);
    x = nop; x.hl = 1; x.br = 1; x.eq = 1; x.idx = 3; x.swe = 1;
                                                    add(x, c, 1, 0, 1, 0);
    x = nop;                                        add(x, c, 1, 0, 1, 0);
    x = nop; x.st = 1;                              add(x, 0, 0, 1, 0, 0);
    x = nop; x.st = 1;                              add(x, 1, 0, 1, 0, 0);
    x = nop; x.rn = 0; x.st = 1;                    add(x, 0, 0, 0, 0, 0);
    x = nop; x.st = 1;                              add(x, 0, 0, 1, 0, 0);
    x = nop; x.br = 1; x.eq = 1; x.idx = 3;         add(x, 0, 0, 1, 0, 0);
    x = nop;                                        add(x, 1, 0, 1, 0, 0);
    foreach (tbl[i]) begin
      tick(tbl[i].i);
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].sc, tbl[i].run, tbl[i].done, tbl[i].ovr);
    end
    x = nop; x.rn = 0; tick(x);
    x = nop; x.st = 1; tick(x);
    for (int i = 0; i < 1023; i++) tick(nop);
    chk_all("pc at end", PC_MAX, 0, 1, 0, 0);
    tick(nop);
    chk_all("overrun halt", PC_MAX, 0, 0, 1, 1);
    tick(nop);
    chk_all("overrun hold", PC_MAX, 0, 0, 1, 1);
    x = nop; x.st = 1; tick(x);
    chk_all("restart clears overrun", 0, 0, 1, 0, 0);
    for (int i = 0; i < 1024; i++) tick(nop);
    chk_all("overrun again", PC_MAX, 0, 0, 1, 1);
    x = nop; x.rn = 0; tick(x);
    chk_all("reset after overrun", 0, 0, 0, 0, 0);
`ifdef PC_FETCH_BRANCH_REL_EN
    x = nop; x.lwe = 1; x.wa = 1; x.wd = 10'h3FE; tick(x);
    x = nop; x.st = 1; tick(x);
    for (int i = 0; i < 10; i++) tick(nop);
    chk_all("rel at 10", 10, 0, 1, 0, 0);
    x = nop; x.br = 1; x.eq = 1; x.idx = 1; tick(x);
    chk_all("rel back 2", 8, 0, 1, 0, 0);
    x = nop; x.rn = 0; tick(x);
    x = nop; x.lwe = 1; x.wa = 1; x.wd = 10'h3FE; tick(x);
    x = nop; x.st = 1; tick(x);
    tick(nop);
    x = nop; x.br = 1; x.eq = 1; x.idx = 1; tick(x);
    chk_all("rel wrap", PC_MAX, 0, 1, 0, 0);
`endif
    x = nop; x.rn = 0; tick(x);
    for (int n = 0; n < 3000; n++) begin
      x.rn  = $urandom_range(0, 59) != 0;
      x.st  = $urandom_range(0, 9) == 0;
      x.hl  = $urandom_range(0, 29) == 0;
      x.br  = $urandom_range(0, 2) == 0;
      x.eq  = $urandom_range(0, 1) == 1;
      x.so  = $urandom_range(0, 1) == 1;
      x.swe = $urandom_range(0, 2) == 0;
      x.lwe = $urandom_range(0, 5) == 0;
      x.idx = LUT_AW'($urandom_range(0, 7));
      x.wa  = LUT_AW'($urandom_range(0, 7));
      x.wd  = PC_W'($urandom);
      tick(x);
      chk_all($sformatf("rand%0d", n), m_pc, m_sc, m_run, m_done, m_ovr);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
